// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, lamp aspects and side one-hot constants
package traffic_pkg;
  typedef enum logic [3:0] {
    MAIN_G, MAIN_Y, AR1, SEEK, SEEK_ADV, SIDE_G, SIDE_Y, AR2, SIDE_DONE
  } state_t;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [3:0] SIDE1 = 4'b0001;
  localparam logic [3:0] SIDE2 = 4'b0010;
  localparam logic [3:0] SIDE3 = 4'b0100;
  localparam logic [3:0] SIDE4 = 4'b1000;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable tick-driven down-counter for phase durations
// ports: clk, reset_n (async, active-low), load/load_val (reload count),
//        tick (decrement enable), done (count is zero on a tick)
module phase_timer #(
  parameter int CNT_W = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             done
);
  logic [CNT_W-1:0] count;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= RST_VAL;
    else if (load) count <= load_val;
    else if (tick && count != '0) count <= count - CNT_W'(1);
  assign done = tick && count == '0;
endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: main/side road phase sequencer driving a one-hot side selector
// ports: clk, reset_n (async, active-low), tick (timebase), T (side sensors),
//        side_sel (selector feedback), next (selector advance strobe),
//        main_light/side_light ({R,Y,G}), side_go (granted side), req_pend (latched requests)
module traffic_phase_ctrl import traffic_pkg::*; #(
  parameter int MAIN_GREEN_MIN = 20,
  parameter int SIDE_GREEN     = 10,
  parameter int YELLOW         = 3,
  parameter int ALL_RED        = 1,
  parameter int CNT_W          = 8,
  parameter int SEEK_MAX       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic [3:0] T,
  input  logic [3:0] side_sel,
  output logic       next,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic [3:0] side_go,
  output logic [3:0] req_pend
);
  localparam int SC_W = $clog2(SEEK_MAX + 1);
  state_t state, state_nx;
  logic [SC_W-1:0] seek_cnt;
  logic [CNT_W-1:0] load_val;
  logic done, load, hit, enter_side;
  assign hit = |(side_sel & req_pend);
  always_comb begin
    state_nx = state;
    case (state)
      MAIN_G:    if (done && |req_pend) state_nx = MAIN_Y;
      MAIN_Y:    if (done) state_nx = AR1;
      AR1:       if (done) state_nx = SEEK;
      SEEK:      state_nx = hit ? SIDE_G : (req_pend == '0 || seek_cnt == SC_W'(SEEK_MAX)) ? MAIN_G : SEEK_ADV;
      SEEK_ADV:  state_nx = SEEK;
      SIDE_G:    if (done) state_nx = SIDE_Y;
      SIDE_Y:    if (done) state_nx = AR2;
      AR2:       if (done) state_nx = SIDE_DONE;
      SIDE_DONE: state_nx = MAIN_G;
      default:   state_nx = MAIN_G;
    endcase
  end
  // the timer reloads with the duration of whichever state is being entered
  assign load = state_nx != state;
  assign load_val = state_nx == MAIN_G ? CNT_W'(MAIN_GREEN_MIN - 1) :
                    state_nx == SIDE_G ? CNT_W'(SIDE_GREEN - 1) :
                    (state_nx == MAIN_Y || state_nx == SIDE_Y) ? CNT_W'(YELLOW - 1) :
                    CNT_W'(ALL_RED - 1);
  assign enter_side = state_nx == SIDE_G && state != SIDE_G;
  phase_timer #(.CNT_W(CNT_W), .RST_VAL(CNT_W'(MAIN_GREEN_MIN - 1))) u_timer (
    .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val), .tick(tick), .done(done)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= MAIN_G;
      req_pend <= '0;
      seek_cnt <= '0;
    end else begin
      state <= state_nx;
      // clearing the served side wins over a same-cycle sensor set
      req_pend <= (req_pend | T) & ~(enter_side ? side_sel : 4'b0000);
      seek_cnt <= (state_nx == AR1 && state != AR1) ? '0 :
                  (state == SEEK && state_nx == SEEK_ADV) ? seek_cnt + SC_W'(1) : seek_cnt;
    end
  assign next = state == SEEK_ADV || state == SIDE_DONE;
  assign main_light = state == MAIN_G ? GRN : state == MAIN_Y ? YEL : RED;
  assign side_light = state == SIDE_G ? GRN : state == SIDE_Y ? YEL : RED;
  assign side_go = state == SIDE_G ? side_sel : 4'b0000;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed bench with a grant scoreboard and a rotating side selector
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;
  logic clk = 0, reset_n = 0, tick = 1;
  logic [3:0] T = 0, T_ab = 0, sel, sel_ab = SIDE1;
  logic next, ab_next;
  logic [2:0] main_light, side_light, ab_main, ab_side;
  logic [3:0] side_go, req_pend, ab_go, ab_req;
  int errors = 0, checks = 0;
  logic [3:0] q[$];
  logic [3:0] prev_go = 0, exp_go;
  always #5 clk = ~clk;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sel <= SIDE1;
    else if (next) sel <= {sel[2:0], sel[3]};
  traffic_phase_ctrl #(.MAIN_GREEN_MIN(4), .SIDE_GREEN(3), .YELLOW(2), .ALL_RED(1), .CNT_W(8), .SEEK_MAX(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .T(T), .side_sel(sel), .next(next),
    .main_light(main_light), .side_light(side_light), .side_go(side_go), .req_pend(req_pend)
  );
  traffic_phase_ctrl #(.MAIN_GREEN_MIN(4), .SIDE_GREEN(3), .YELLOW(2), .ALL_RED(1), .CNT_W(8), .SEEK_MAX(2)) u_abort (
    .clk(clk), .reset_n(reset_n), .tick(tick), .T(T_ab), .side_sel(sel_ab), .next(ab_next),
    .main_light(ab_main), .side_light(ab_side), .side_go(ab_go), .req_pend(ab_req)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    step();
    reset_n = 0;
    T = 0;
    T_ab = 0;
    step();
    reset_n = 1;
  endtask
  always @(negedge clk) begin
    checks++;
    assert ((main_light == RED || side_light == RED) && $onehot0(side_go)) else begin
      errors++;
      $error("FAIL safety observed=main %b side %b go %b expected=one road red, go onehot0", main_light, side_light, side_go);
    end
    if (side_go != 0 && prev_go == 0) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL grant_unexpected observed=%b expected=none", side_go);
      end
      if (q.size() != 0) begin
        exp_go = q.pop_front();
        checks++;
        assert (side_go === exp_go) else begin
          errors++;
          $error("FAIL grant_order observed=%b expected=%b", side_go, exp_go);
        end
      end
    end
    prev_go = side_go;
  end
  initial begin
    int nx, found, run, minrun;
    step();
    chk("reset_vals", {main_light, side_light, side_go, req_pend, next}, {GRN, RED, 4'b0, 4'b0, 1'b0});
    reset_n = 1;
    for (int c = 0; c < 50; c++) begin
      chk("idle", {main_light, next}, {GRN, 1'b0});
      step();
    end
    do_reset();
    T = SIDE1;
    q.push_back(SIDE1);
    nx = 0;
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) begin
        step();
        T = 0;
      end
      nx += int'(next);
      if (c == 0) chk("sr_c0", {main_light, req_pend}, {GRN, 4'b0});
      if (c == 1) chk("sr_latch", req_pend, SIDE1);
      if (c == 3) chk("sr_mg_end", main_light, GRN);
      if (c == 4) chk("sr_main_y", main_light, YEL);
      if (c == 6 || c == 7) chk("sr_allred", {main_light, side_light}, {RED, RED});
      if (c == 8) chk("sr_side_g", {side_light, side_go, req_pend}, {GRN, SIDE1, 4'b0});
      if (c == 10) chk("sr_side_g_last", side_go, SIDE1);
      if (c == 11) chk("sr_side_y", {side_light, side_go}, {YEL, 4'b0});
      if (c == 13) chk("sr_ar2", side_light, RED);
      if (c == 14) chk("sr_done_next", next, 1);
      if (c == 15) chk("sr_back_main", {main_light, next}, {GRN, 1'b0});
    end
    chk("sr_nexts", nx, 1);
    do_reset();
    T = SIDE3;
    q.push_back(SIDE3);
    nx = 0;
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      if (c > 0) begin
        step();
        T = 0;
      end
      nx += int'(next);
      found = int'(side_go != 0);
    end
    chk("seek_found", found, 1);
    chk("seek_nexts", nx, 2);
    chk("seek_go", {side_go, req_pend}, {SIDE3, 4'b0});
    do_reset();
    T = 4'b1111;
    q.push_back(SIDE1);
    q.push_back(SIDE2);
    q.push_back(SIDE3);
    q.push_back(SIDE4);
    run = 0;
    minrun = 1000;
    for (int c = 0; c < 200 && q.size() != 0; c++) begin
      if (c > 0) begin
        step();
        T = 0;
      end
      if (main_light == GRN) run++;
      else if (run > 0) begin
        if (run < minrun) minrun = run;
        run = 0;
      end
    end
    chk("sim_all_served", q.size(), 0);
    chk("sim_min_main_green", int'(minrun >= 4), 1);
    chk("sim_req_clear", req_pend, 0);
    do_reset();
    T = SIDE1;
    q.push_back(SIDE1);
    found = 0;
    for (int c = 0; c < 30 && found == 0; c++) begin
      if (c > 0) begin
        step();
        T = 0;
      end
      found = int'(side_go != 0);
    end
    chk("rm_found", found, 1);
    T = SIDE2;
    step();
    T = 0;
    step();
    chk("rm_pre", {side_go, req_pend}, {SIDE1, SIDE2});
    #2 reset_n = 0;
    #1 chk("rm_async", {main_light, side_light, side_go, req_pend, next}, {GRN, RED, 4'b0, 4'b0, 1'b0});
    step();
    reset_n = 1;
    do_reset();
    T_ab = SIDE4;
    nx = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      T_ab = 0;
      nx += int'(ab_next);
      if (c == 11) chk("ab_seek_red", ab_main, RED);
    end
    chk("ab_back_main", {ab_main, ab_req}, {GRN, SIDE4});
    chk("ab_nexts", nx, 2);
    chk("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
